// File: rtl/color_word_packer_if.sv
// Handshake bundle between the colour detector, the word packer and the
// downstream ROM-read logic.
interface color_word_packer_if #(
    parameter int SYMBOLS_PER_WORD = 4
);
    logic                            readRequest;
    logic                            startDetection;
    logic                            detectionComplete;
    logic [1:0]                      color;
    logic [2*SYMBOLS_PER_WORD-1:0]   wordOut;
    logic                            wordValid;
    logic                            wordReady;
    logic                            busy;
    logic                            timeoutError;

    modport master (
        input  readRequest,
        input  detectionComplete,
        input  color,
        input  wordReady,
        output startDetection,
        output wordOut,
        output wordValid,
        output busy,
        output timeoutError
    );

    modport slave (
        output readRequest,
        output detectionComplete,
        output color,
        output wordReady,
        input  startDetection,
        input  wordOut,
        input  wordValid,
        input  busy,
        input  timeoutError
    );
endinterface

// File: rtl/color_word_packer.sv
// Runs SYMBOLS_PER_WORD colour detections, packs the 2-bit results MSB-first
// into one word and offers it downstream on a valid/ready handshake.
module color_word_packer #(
    parameter int SYMBOLS_PER_WORD = 4,
    parameter int TIMEOUT_CYCLES   = 2000000
) (
    input  logic                 clk,
    input  logic                 reset,
    color_word_packer_if.master  bus
);
    localparam int W     = 2 * SYMBOLS_PER_WORD;
    localparam int CNT_W = $clog2(SYMBOLS_PER_WORD) + 1;
    localparam int WD_W  = 24;

    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(SYMBOLS_PER_WORD - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRIGGER = 2'd1,
        S_WAIT    = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [W-1:0]     word_q, word_d;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.readRequest) begin
                    state_d = S_TRIGGER;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    shift_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TRIGGER: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response on the expiry cycle still counts as a valid symbol.
                if (bus.detectionComplete) begin
                    shift_d = {shift_q[W-3:0], bus.color};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_SYM) begin
                        state_d = S_OUTPUT;
                    end else begin
                        state_d = S_TRIGGER;
                    end
                end else if (wd_q == WD_LIMIT) begin
                    err_d   = 1'b1;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_OUTPUT: begin
                if (valid_q && bus.wordReady) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUTPUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it.
        start_d = (state_d == S_TRIGGER);
        valid_d = (state_d == S_OUTPUT);
        busy_d  = (state_d != S_IDLE);
        word_d  = (state_d == S_OUTPUT) ? shift_d : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            start_q <= start_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            word_q  <= word_d;
        end
    end

    assign bus.startDetection = start_q;
    assign bus.wordValid      = valid_q;
    assign bus.wordOut        = word_q;
    assign bus.busy           = busy_q;
    assign bus.timeoutError   = err_q;
endmodule

// File: tb/tb_color_word_packer.sv
// Directed, table-driven bench for color_word_packer (4 symbols, 100-cycle watchdog).
module tb_color_word_packer;
    localparam int N  = 4;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic reset;

    color_word_packer_if #(.SYMBOLS_PER_WORD(N)) bus ();

    color_word_packer #(
        .SYMBOLS_PER_WORD(N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Pulse and width monitor, sampled mid-cycle.
    int   start_pulses = 0;
    int   start_run    = 0;
    int   start_maxw   = 0;
    int   valid_cycles = 0;
    logic start_prev   = 1'b0;

    always @(negedge clk) begin
        if (bus.startDetection) begin
            if (!start_prev) start_pulses <= start_pulses + 1;
            start_run <= start_run + 1;
            if (start_run + 1 > start_maxw) start_maxw <= start_run + 1;
        end else begin
            start_run <= 0;
        end
        start_prev <= bus.startDetection;
        if (bus.wordValid) valid_cycles <= valid_cycles + 1;
    end

    typedef struct {
        logic [7:0] syms;
        int         resp_delay;
        int         ready_delay;
        bit         stray_req;
        logic [7:0] exp_word;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, 32'(bus.startDetection), 32'd0);
        check({tag, "_valid"}, 32'(bus.wordValid), 32'd0);
        check({tag, "_word"},  32'(bus.wordOut), 32'd0);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_err"},   32'(bus.timeoutError), 32'd0);
    endtask

    // Full capture: request, detector model answers each trigger, then handshake.
    task automatic capture(input logic [7:0] syms, input int resp_delay, input int ready_delay,
                           input bit stray_req, input logic [7:0] exp_word);
        int p0, w0, guard;
        p0 = start_pulses;
        w0 = valid_cycles;
        bus.wordReady   = (ready_delay == 0);
        bus.readRequest = 1'b1;
        tick();
        bus.readRequest = 1'b0;
        check("req_start_latency", 32'(bus.startDetection), 32'd1);
        check("req_clears_err", 32'(bus.timeoutError), 32'd0);
        check("req_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            guard = 0;
            while (!bus.startDetection && guard < 8) begin
                tick();
                guard++;
            end
            check("start_seen", 32'(bus.startDetection), 32'd1);
            for (int d = 0; d < resp_delay; d++) begin
                bus.readRequest = stray_req && (d == resp_delay - 1);
                tick();
            end
            bus.readRequest       = 1'b0;
            bus.detectionComplete = 1'b1;
            bus.color             = syms[7-2*i -: 2];
            tick();
            bus.detectionComplete = 1'b0;
            bus.color             = 2'b00;
            if (i < N - 1) begin
                check("next_start_latency", 32'(bus.startDetection), 32'd1);
            end else begin
                check("valid_latency", 32'(bus.wordValid), 32'd1);
                check("word", 32'(bus.wordOut), 32'(exp_word));
            end
        end
        for (int r = 0; r < ready_delay; r++) begin
            tick();
            check("valid_hold", 32'(bus.wordValid), 32'd1);
            check("word_hold", 32'(bus.wordOut), 32'(exp_word));
        end
        bus.wordReady   = 1'b1;
        bus.readRequest = stray_req;
        tick();
        bus.readRequest = 1'b0;
        check("valid_drop", 32'(bus.wordValid), 32'd0);
        check("busy_after_xfer", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle_no_start", 32'(bus.startDetection), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end
        check("start_pulse_count", 32'(start_pulses - p0), 32'(N));
        check("valid_cycle_count", 32'(valid_cycles - w0), 32'(ready_delay + 1));
        check("no_timeout", 32'(bus.timeoutError), 32'd0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{syms: 8'hC6, resp_delay: 1,   ready_delay: 0,  stray_req: 1'b0, exp_word: 8'hC6};
        vecs[1] = '{syms: 8'hC6, resp_delay: 1,   ready_delay: 20, stray_req: 1'b0, exp_word: 8'hC6};
        vecs[2] = '{syms: 8'h93, resp_delay: 2,   ready_delay: 3,  stray_req: 1'b0, exp_word: 8'h93};
        vecs[3] = '{syms: 8'hFF, resp_delay: 3,   ready_delay: 0,  stray_req: 1'b1, exp_word: 8'hFF};
        vecs[4] = '{syms: 8'h00, resp_delay: 1,   ready_delay: 1,  stray_req: 1'b0, exp_word: 8'h00};
        vecs[5] = '{syms: 8'hC6, resp_delay: TO,  ready_delay: 0,  stray_req: 1'b0, exp_word: 8'hC6};

        reset                 = 1'b1;
        bus.readRequest       = 1'b0;
        bus.detectionComplete = 1'b0;
        bus.color             = 2'b00;
        bus.wordReady         = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            capture(vecs[v].syms, vecs[v].resp_delay, vecs[v].ready_delay,
                    vecs[v].stray_req, vecs[v].exp_word);
        end

        // Watchdog: one symbol, then the detector goes silent.
        begin
            int w0;
            w0 = valid_cycles;
            bus.wordReady   = 1'b1;
            bus.readRequest = 1'b1;
            tick();
            bus.readRequest = 1'b0;
            tick();
            bus.detectionComplete = 1'b1;
            bus.color             = 2'b10;
            tick();
            bus.detectionComplete = 1'b0;
            check("to_second_start", 32'(bus.startDetection), 32'd1);
            for (int j = 0; j < TO; j++) tick();
            check("to_not_yet", 32'(bus.timeoutError), 32'd0);
            check("to_still_busy", 32'(bus.busy), 32'd1);
            tick();
            check("to_set", 32'(bus.timeoutError), 32'd1);
            check("to_idle", 32'(bus.busy), 32'd0);
            tick();
            tick();
            check("to_sticky", 32'(bus.timeoutError), 32'd1);
            check("to_no_valid", 32'(valid_cycles - w0), 32'd0);
        end
        capture(8'h1B, 1, 0, 1'b0, 8'h1B);

        // Reset mid-capture, then a stray late detection.
        bus.readRequest = 1'b1;
        tick();
        bus.readRequest = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.detectionComplete = 1'b1;
            bus.color             = 2'b11;
            tick();
            bus.detectionComplete = 1'b0;
        end
        tick();
        tick();
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("mid_reset");
        bus.detectionComplete = 1'b1;
        bus.color             = 2'b11;
        tick();
        bus.detectionComplete = 1'b0;
        bus.color             = 2'b00;
        tick();
        check_all_zero("stray");
        capture(8'h55, 1, 0, 1'b0, 8'h55);

        check("start_width_max", 32'(start_maxw), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end
endmodule
